mdu_ctrl: RTL

//  Multi-cycle multiply/divide unit with its own sequencing control, sitting beside the

---
 rtl/mdu_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit that sits beside the single-cycle ALU.
//   MULU/MULS use a shift-add loop and DIVU/DIVS use a restoring divide.
//   Each op runs one iteration per cycle, WIDTH iterations in total.
//   Signed operands are reduced to magnitudes when the request is accepted.
//   The sign is restored on the final iteration, as the results are registered.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, op, a, b     request; op 00 MULU, 01 MULS, 10 DIVU, 11 DIVS;
//                       accepted only in IDLE
//   flush               synchronous abort; returns to IDLE with no done
//   busy                high in RUN and DONE (pipeline stall)
//   done                one-cycle pulse; result_* and div_zero are valid
//   result_lo/hi        MUL: product low/high half. DIV: quotient/remainder
//   div_zero            divide with b==0; held until the next accepted start
//
// Handshake: start is a level request, not a queued one. It is consumed in the
// first cycle in which the unit is IDLE and flush is low. It is ignored while
// busy, so the caller keeps start asserted until busy rises.
module mdu_ctrl #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_q;     // negate product / quotient at the end
    logic             neg_r;     // negate remainder at the end (dividend sign)
    logic [WIDTH-1:0] opb;       // multiplicand (MUL) or divisor (DIV) magnitude
    logic [WIDTH-1:0] acc_hi;    // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;    // multiplier (shifts out) / dividend->quotient

    // Operand magnitudes computed at accept time.
    logic             op_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;

    always_comb begin
        op_signed = op[0];
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
        accept    = (state == S_IDLE) && start && !flush;
    end

    // One iteration of the active algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (is_div) begin
            // Restoring step: keep the difference only when it did not borrow.
            hi_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo_nxt = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod_fix = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        // The most-negative / -1 overflow lands on quotient = a naturally:
        // the magnitude 2^(W-1) negated in W bits is itself.
        quo_fix  = neg_q ? -lo_nxt : lo_nxt;
        rem_fix  = neg_r ? -hi_nxt : hi_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            opb       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
        end else if (flush) begin
            // Abort: results and div_zero keep their prior values.
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        is_div <= op[1];
                        neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= op_signed && op[1] && a[WIDTH-1];
                        opb    <= op[1] ? b_mag : a_mag;
                        acc_hi <= '0;
                        acc_lo <= op[1] ? a_mag : b_mag;
                        busy   <= 1'b1;
                        if (op[1] && (b == '0)) begin
                            // Divide by zero short-circuits straight to DONE.
                            state     <= S_DONE;
                            done      <= 1'b1;
                            result_lo <= '1;
                            result_hi <= a;
                            div_zero  <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            cnt      <= CNT_W'(WIDTH);
                            div_zero <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    acc_hi <= hi_nxt;
                    acc_lo <= lo_nxt;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        if (is_div) begin
                            result_lo <= quo_fix;
                            result_hi <= rem_fix;
                        end else begin
                            result_lo <= prod_fix[WIDTH-1:0];
                            result_hi <= prod_fix[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
